sha256_msg_sched: RTL and testbench
===================================

// Module: sha256_msg_sched
// PURPOSE
//  SHA-256 message-schedule generator. Accepts one 512-bit block as 16 x 32-bit words (W0..W15) over a
//  valid/ready input stream and emits W0..W(NUM_ROUNDS-1) over a valid/ready output stream, one word per
//  handshake. Sits between the block loader and the compression round engine; the round engine reads
//  W_t for round t from this block.
// PARAMETERS
//  NUM_ROUNDS  64  words emitted per block; legal range 16..64
// PORTS
//  clock      in   1   single clock; all state changes on posedge
//  reset      in   1   synchronous, active-high
//  in_valid   in   1   in_word holds a valid message word
//  in_ready   out  1   block accepts a message word this cycle
//  in_word    in   32  message word, big-endian word order, W0 first
//  out_valid  out  1   out_word/out_index hold W_t
//  out_ready  in   1   consumer accepts W_t this cycle
//  out_word   out  32  W_t
//  out_index  out  6   t, 0..NUM_ROUNDS-1
//  busy       out  1   high while state is EMIT
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high (ports clock, reset).
//  Storage: 16-entry x 32-bit shift window win[0..15]; 6-bit counter cnt.
//  Functions: ROTR = rotate right, SHR = logical shift right.
//   s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
//   s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
//   nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32; carries are discarded.
//  States: LOAD, EMIT.
//  Reset: state=LOAD, cnt=0, win all 0, in_ready=1, out_valid=0, out_word=0, out_index=0, busy=0.
//  LOAD:
//   in_ready=1, out_valid=0.
//   On in_valid&&in_ready: win shifts down (win[i] <= win[i+1]), win[15] <= in_word, cnt++.
//   On the 16th accept: cnt <= 0, state <= EMIT. win[0]=W0, the first accepted word.
//  EMIT:
//   in_ready=0; in_valid is ignored.
//   out_valid=1, out_word=win[0], out_index=cnt.
//   On out_valid&&out_ready: win shifts down, win[15] <= nxt, cnt++.
//    Invariant: after t accepts, win[0]=W_t.
//   On the accept with cnt==NUM_ROUNDS-1: cnt <= 0, state <= LOAD.
//  Latency:
//   First out_valid in the cycle after the 16th input accept.
//   With out_ready held at 1: one word per cycle, no bubbles.
//   in_ready rises the cycle after the last output accept.
//  Stall: while out_valid && !out_ready, out_word and out_index hold stable and nothing shifts.
//  Registers: out_word and out_index come straight from registers (win[0], cnt); no combinational path
//   from out_ready to out_word. in_ready and out_valid are decoded from the state register only.
//  Reset mid-operation: reset has priority over any handshake in that cycle. Any partial load or
//   emission is abandoned and state returns to the reset values above.
//  Input gaps: in_valid may drop between words; partial loads are held indefinitely.
// TESTING
//  1. Reset, then load the "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, all out_ready=1
//     -> out_index 0..63 in consecutive cycles; W0=0x61626380, W15=0x00000018, W16=0x61626380,
//     W17=0x000F0000; all 64 words match the C reference model.
//  2. Same block with out_ready toggled pseudo-randomly -> identical word sequence;
//     out_word/out_index stable on every stalled cycle.
//  3. Input gaps (in_valid low 3 cycles between words) and in_valid held high during EMIT
//     -> no extra words absorbed; output identical to test 1.
//  4. Assert reset after 9 input words, then again at out_index=30
//     -> reset values next cycle; a fresh full block afterwards produces the correct schedule.
//  5. Two back-to-back blocks (second block all 0xFFFFFFFF)
//     -> in_ready=0 throughout EMIT; second schedule matches the model; no words carried over from block 1.
//  6. NUM_ROUNDS=16 build
//     -> exactly W0..W15 echoed unchanged, then return to LOAD.

Source files
------------

// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: message-word input stream and schedule-word output stream
interface sha256_msg_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_index;
    logic        busy;
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_index, busy
    );
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_index, busy
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: loads W0..W15, then emits W0..W(NUM_ROUNDS-1) from a 16-word shift window
module sha256_msg_sched #(
    parameter int NUM_ROUNDS = 64
) (
    input logic clock,
    input logic reset,
    sha256_msg_sched_if.slave bus
);
    typedef enum logic {LOAD, EMIT} state_t;
    state_t state, state_nxt;
    logic [31:0] win [16];
    logic [5:0] cnt;
    logic [31:0] nxt;
    logic acc, last;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    assign nxt  = s1(win[14]) + win[9] + s0(win[1]) + win[0];
    assign acc  = state == LOAD ? bus.in_valid : bus.out_ready;
    assign last = cnt == (state == LOAD ? 6'd15 : 6'(NUM_ROUNDS - 1));

    always_ff @(posedge clock)
        state <= reset ? LOAD : state_nxt;

    always_comb
        state_nxt = acc && last ? (state == LOAD ? EMIT : LOAD) : state;

    always_comb begin
        bus.in_ready  = state == LOAD;
        bus.out_valid = state == EMIT;
        bus.busy      = state == EMIT;
    end

    // Outputs are taken straight from the window head and counter registers.
    assign bus.out_word  = win[0];
    assign bus.out_index = cnt;

    // Loading and emitting share one shift; only the word entering win[15] differs.
    always_ff @(posedge clock)
        if (reset) begin
            win <= '{default: '0};
            cnt <= '0;
        end else if (acc) begin
            for (int i = 0; i < 15; i++)
                win[i] <= win[i + 1];
            win[15] <= state == LOAD ? bus.in_word : nxt;
            cnt <= last ? '0 : cnt + 6'd1;
        end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized checks of the schedule generator against a recurrence model
module tb_sha256_msg_sched;
    localparam int NR = 64;
    logic clock = 0;
    logic reset = 1;
    int tests = 0;
    int fails = 0;
    logic [31:0] blk [16];
    logic [31:0] exp_w [NR];
    logic [31:0] got_w [NR];
    int cycles;

    sha256_msg_sched_if bus();
    sha256_msg_sched_if bus16();

    sha256_msg_sched #(.NUM_ROUNDS(NR)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    sha256_msg_sched #(.NUM_ROUNDS(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16.slave));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrence over the whole W array.
    task automatic build_ref;
        for (int t = 0; t < NR; t++)
            exp_w[t] = t < 16 ? blk[t] :
                (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) + exp_w[t-7] +
                (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) + exp_w[t-16];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_out_index"}, bus.out_index, 0);
        check({tag, "_out_word"}, bus.out_word, 0);
    endtask

    task automatic load(input int n_words, input int gap);
        for (int i = 0; i < n_words; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 0;
                bus.in_word = $urandom;
                step;
            end
            check("in_ready_load", bus.in_ready, 1);
            check("out_valid_load", bus.out_valid, 0);
            bus.in_valid = 1;
            bus.in_word = blk[i];
            step;
        end
        bus.in_valid = 0;
    endtask

    task automatic collect(input int ready_pct, input int abort_at, input bit hold_in, output int n);
        int t = 0;
        bit take;
        n = 0;
        check("first_valid", bus.out_valid, 1);
        while (t < NR && n < 2000) begin
            bus.out_ready = $urandom_range(99) < ready_pct;
            bus.in_valid = hold_in;
            bus.in_word = $urandom;
            check("out_valid_emit", bus.out_valid, 1);
            check("in_ready_emit", bus.in_ready, 0);
            check("busy_emit", bus.busy, 1);
            check($sformatf("index_%0d", t), bus.out_index, t);
            check($sformatf("word_%0d", t), bus.out_word, exp_w[t]);
            got_w[t] = bus.out_word;
            if (t == abort_at) begin
                reset = 1;
                step;
                reset = 0;
                bus.out_ready = 0;
                bus.in_valid = 0;
                return;
            end
            take = bus.out_valid && bus.out_ready;
            step;
            n++;
            if (take) t++;
        end
        check("emit_timeout", t, NR);
        bus.out_ready = 0;
        bus.in_valid = 0;
        check("in_ready_after", bus.in_ready, 1);
        check("out_valid_after", bus.out_valid, 0);
        check("busy_after", bus.busy, 0);
    endtask

    task automatic abc_block;
        blk = '{default: '0};
        blk[0] = 32'h61626380;
        blk[15] = 32'h00000018;
        build_ref;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_word = 0; bus.out_ready = 0;
        bus16.in_valid = 0; bus16.in_word = 0; bus16.out_ready = 0;
        step;
        step;
        check_reset("reset");
        reset = 0;

        abc_block;
        load(16, 0);
        collect(100, -1, 0, cycles);
        check("abc_cycles", cycles, NR);
        check("abc_w0", got_w[0], 32'h61626380);
        check("abc_w15", got_w[15], 32'h00000018);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000F0000);

        load(16, 0);
        collect(50, -1, 0, cycles);

        load(16, 3);
        collect(100, -1, 1, cycles);

        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_ref;
        load(9, 0);
        reset = 1;
        step;
        reset = 0;
        check_reset("rst_load");
        load(16, 0);
        collect(70, 30, 0, cycles);
        check_reset("rst_emit");
        load(16, 0);
        collect(100, -1, 0, cycles);

        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = b == 0 ? $urandom : 32'hFFFFFFFF;
            build_ref;
            load(16, b);
            collect(80, -1, 1, cycles);
        end

        for (int i = 0; i < 16; i++) begin
            blk[i] = $urandom;
            bus16.in_valid = 1;
            bus16.in_word = blk[i];
            step;
        end
        bus16.in_valid = 0;
        bus16.out_ready = 1;
        for (int t = 0; t < 16; t++) begin
            check("r16_valid", bus16.out_valid, 1);
            check($sformatf("r16_index_%0d", t), bus16.out_index, t);
            check($sformatf("r16_word_%0d", t), bus16.out_word, blk[t]);
            step;
        end
        bus16.out_ready = 0;
        check("r16_in_ready", bus16.in_ready, 1);
        check("r16_out_valid", bus16.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
